// File: rtl/wavefront_sequencer.sv
// ---------------------------------------------------------------------------
// wavefront_sequencer
//
// Purpose: walks a single active position (one-hot) or a growing prefix of
// positions (thermometer) across WIDTH enable lines. This is the per-PE
// enable wavefront for the systolic array. The walk is started by the layer
// controller and reports completion back to it.
//
// Optional feature: define WAVEFRONT_SEQ_WRAP_EN to make the walk restart at
// position 0 after the last position, instead of stopping in DONE. In that
// build the walk repeats until enable drops.
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       synchronous active-high reset, highest priority
//   enable      level run request; low aborts and clears the sequence
//   hold        stall; freezes the walk while in RUN and blocks the start
//   mode        0 = one-hot, 1 = thermometer (sampled at start)
//   len         number of positions to walk (sampled at start; 0 or >WIDTH
//               means WIDTH)
//   shifout     position vector
//   pos         index of the current active position
//   busy        high while in RUN
//   done        one-cycle pulse when the final position retires
//   vld         sticky "sequence completed" flag, cleared when enable drops
//   dbg_state_o current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: enable is a level request, not a valid/ready pair. The walk
// advances one position on every clock edge with enable=1 and hold=0. The
// requester observes completion through done/vld and releases the block by
// dropping enable.
// ---------------------------------------------------------------------------
module wavefront_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             hold,
    input  logic             mode,
    input  logic [CNT_W-1:0] len,
    output logic [WIDTH-1:0] shifout,
    output logic [CNT_W-1:0] pos,
    output logic             busy,
    output logic             done,
    output logic             vld,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shifout_q;
    logic [CNT_W-1:0] pos_q;
    logic [CNT_W-1:0] len_q;
    logic             mode_q;
    logic             busy_q;
    logic             done_q;
    logic             vld_q;

    logic [CNT_W-1:0] len_d;
    logic [CNT_W-1:0] last_pos;

    // A zero or oversize run length saturates to the full array width.
    always_comb begin
        len_d = len;
        if (len == '0 || len > CNT_W'(WIDTH)) begin
            len_d = CNT_W'(WIDTH);
        end
    end

    assign last_pos = len_q - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shifout_q <= '0;
            pos_q     <= '0;
            len_q     <= '0;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vld_q     <= 1'b0;
        end else if (!enable) begin
            // Dropping enable aborts from any state and wins over hold.
            state_q   <= S_IDLE;
            shifout_q <= '0;
            pos_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!hold) begin
                        len_q     <= len_d;
                        mode_q    <= mode;
                        state_q   <= S_RUN;
                        shifout_q <= WIDTH'(1);
                        pos_q     <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        if (pos_q == last_pos) begin
                            done_q <= 1'b1;
                            vld_q  <= 1'b1;
                            pos_q  <= '0;
`ifdef WAVEFRONT_SEQ_WRAP_EN
                            // Restart the walk. len_q and mode_q keep the
                            // values from the original start.
                            shifout_q <= WIDTH'(1);
`else
                            shifout_q <= '0;
                            state_q   <= S_DONE;
                            busy_q    <= 1'b0;
`endif
                        end else begin
                            pos_q <= pos_q + CNT_W'(1);
                            // Thermometer keeps every retired position lit.
                            if (mode_q) begin
                                shifout_q <= shifout_q | (shifout_q << 1);
                            end else begin
                                shifout_q <= shifout_q << 1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // Park with outputs cleared until enable drops.
                    shifout_q <= '0;
                    pos_q     <= '0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    shifout_q <= '0;
                    pos_q     <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign shifout     = shifout_q;
    assign pos         = pos_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign vld         = vld_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wavefront_sequencer.sv
module tb_wavefront_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             hold = 1'b0;
  logic             mode = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic [WIDTH-1:0] shifout;
  logic [CNT_W-1:0] pos;
  logic             busy;
  logic             done;
  logic             vld;
  logic [1:0]       dbg_state_o;

  wavefront_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .hold(hold),
    .mode(mode),
    .len(len),
    .shifout(shifout),
    .pos(pos),
    .busy(busy),
    .done(done),
    .vld(vld),
    .dbg_state_o(dbg_state_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: a walk is "running" with k positions already passed.
  // Outputs are derived arithmetically from (running, k, mode).
  bit m_running = 0;
  bit m_parked = 0;
  int m_k = 0;
  int m_len = 0;
  bit m_mode = 0;
  bit m_vld = 0;
  bit m_done = 0;

  task automatic model_step(input bit r, input bit e, input bit h, input bit md, input int l);
    if (r) begin
      m_running = 0; m_parked = 0; m_k = 0; m_len = 0; m_mode = 0; m_vld = 0; m_done = 0;
    end else if (!e) begin
      m_running = 0; m_parked = 0; m_k = 0; m_vld = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_running && !m_parked) begin
        if (!h) begin
          m_len = (l == 0 || l > WIDTH) ? WIDTH : l;
          m_mode = md;
          m_running = 1;
          m_k = 0;
        end
      end else if (m_running && !h) begin
        if (m_k + 1 >= m_len) begin
          m_done = 1;
          m_vld = 1;
          m_k = 0;
`ifndef WAVEFRONT_SEQ_WRAP_EN
          m_running = 0;
          m_parked = 1;
`endif
        end else begin
          m_k = m_k + 1;
        end
      end
    end
  endtask

  function automatic int exp_shift();
    if (!m_running) return 0;
    return m_mode ? ((1 << (m_k + 1)) - 1) : (1 << m_k);
  endfunction

  // driver task: apply inputs, clock once, advance the model, compare at +1
  task automatic drive_cycle(input bit r, input bit e, input bit h, input bit md, input int l);
    reset = r; enable = e; hold = h; mode = md; len = CNT_W'(l);
    @(posedge clk);
    model_step(r, e, h, md, l);
    #1;
    check_eq("shifout", 32'(shifout), 32'(exp_shift()));
    check_eq("pos", 32'(pos), m_running ? 32'(m_k) : 32'd0);
    check_eq("busy", 32'(busy), 32'(m_running));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("vld", 32'(vld), 32'(m_vld));
  endtask

  logic [WIDTH-1:0] exp_q[$];
  int done_count;

  initial begin
    // reset state
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0);
    check_eq("reset_shifout", 32'(shifout), 32'd0);
    check_eq("reset_state", 32'(dbg_state_o), 32'd0);

    // full-width one-hot walk, len=0 saturates to WIDTH
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(WIDTH'(1) << i);
    exp_q.push_back('0);
    for (int i = 0; i <= WIDTH; i++) begin
      drive_cycle(0, 1, 0, 0, 0);
      check_eq("seq1_shift", 32'(shifout), 32'(exp_q.pop_front()));
    end
    check_eq("seq1_done", 32'(done), 32'd1);
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, 0, 0);
    check_eq("seq1_vld_held", 32'(vld), 32'd1);

    // thermometer len=3, with len/mode changed mid-run
    drive_cycle(0, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 1, 3);
    for (int i = 0; i < 5; i++) drive_cycle(0, 1, 0, 0, 7);

    // hold for 3 cycles at pos=2
    drive_cycle(0, 0, 0, 0, 0);
    done_count = 0;
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, 0, 0);
    check_eq("hold_pre", 32'(shifout), 32'h04);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 1, 1, 0, 0);
      check_eq("hold_frozen", 32'(pos), 32'd2);
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(0, 1, 0, 0, 0);
      done_count += int'(done);
    end
    check_eq("hold_done_once", 32'(done_count), 32'd1);

    // drop enable at pos=4, restart, then drop in DONE
    drive_cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive_cycle(0, 1, 0, 0, 0);
    drive_cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) drive_cycle(0, 1, 0, 0, 5);
    drive_cycle(0, 0, 0, 0, 0);

    // reset mid-run, len=12 saturation, hold blocks start
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, 1, 0);
    drive_cycle(1, 1, 0, 1, 0);
    for (int i = 0; i < 10; i++) drive_cycle(0, 1, 0, 0, 12);
    drive_cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 1, 0, 2);
    check_eq("hold_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) drive_cycle(0, 1, 0, 0, 2);
    drive_cycle(0, 0, 0, 0, 0);

    // randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 24) != 0,
                  $urandom_range(0, 4) == 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 15));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
